// File: rtl/switch_debouncer.sv
// switch_debouncer
// Conditions raw board switch/button levels for the lab gate inputs.
// Each channel gets a two-flop synchronizer and a four-state debounce FSM.
// The clean level drives the gates. One-cycle rise/fall pulses go to the
// counter and LED logic. All outputs are registered, so no combinational
// path exists from sw_raw to any output.

module switch_debouncer #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 4   // legal range 1..65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    // The counter holds 0..DEBOUNCE_CYCLES and saturates at the top value.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_t;

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;

    // Two-flop synchronizer. The FSMs only ever look at sync2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= sw_raw;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            state_t           state_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             clean_reg;
            logic             rise_reg;
            logic             fall_reg;
            logic             smp;

            assign smp = sync2_reg[gi];

            // Debounce FSM. The clean level and its edge pulse are updated
            // together on the completing edge. Pulses drop after one cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= STABLE_LOW;
                    cnt_reg   <= '0;
                    clean_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                    case (state_reg)
                        STABLE_LOW: begin
                            if (smp) begin
                                // A one-sample debounce needs no check phase.
                                if (SINGLE) begin
                                    state_reg <= STABLE_HIGH;
                                    clean_reg <= 1'b1;
                                    rise_reg  <= 1'b1;
                                    cnt_reg   <= '0;
                                end else begin
                                    state_reg <= CHECK_HIGH;
                                    cnt_reg   <= CNT_ONE;
                                end
                            end else begin
                                cnt_reg <= '0;
                            end
                        end
                        CHECK_HIGH: begin
                            if (!smp) begin
                                // Glitch rejected. The output never moved.
                                state_reg <= STABLE_LOW;
                                cnt_reg   <= '0;
                            end else if (cnt_reg == CNT_LAST) begin
                                state_reg <= STABLE_HIGH;
                                clean_reg <= 1'b1;
                                rise_reg  <= 1'b1;
                                cnt_reg   <= '0;
                            end else if (cnt_reg != CNT_MAX) begin
                                cnt_reg <= cnt_reg + 1'b1;
                            end
                        end
                        STABLE_HIGH: begin
                            if (!smp) begin
                                if (SINGLE) begin
                                    state_reg <= STABLE_LOW;
                                    clean_reg <= 1'b0;
                                    fall_reg  <= 1'b1;
                                    cnt_reg   <= '0;
                                end else begin
                                    state_reg <= CHECK_LOW;
                                    cnt_reg   <= CNT_ONE;
                                end
                            end else begin
                                cnt_reg <= '0;
                            end
                        end
                        CHECK_LOW: begin
                            if (smp) begin
                                state_reg <= STABLE_HIGH;
                                cnt_reg   <= '0;
                            end else if (cnt_reg == CNT_LAST) begin
                                state_reg <= STABLE_LOW;
                                clean_reg <= 1'b0;
                                fall_reg  <= 1'b1;
                                cnt_reg   <= '0;
                            end else if (cnt_reg != CNT_MAX) begin
                                cnt_reg <= cnt_reg + 1'b1;
                            end
                        end
                        default: begin
                            state_reg <= STABLE_LOW;
                            cnt_reg   <= '0;
                            clean_reg <= 1'b0;
                        end
                    endcase
                end
            end

            assign sw_clean[gi] = clean_reg;
            assign sw_rise[gi]  = rise_reg;
            assign sw_fall[gi]  = fall_reg;
        end
    endgenerate

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer.
// The dut instance uses the default of 4 debounce samples.
// The dut1 instance uses a single debounce sample.
// A raw level applied before edge k is seen by the FSM at edge k+2.
// The output changes at edge k+1+DEBOUNCE_CYCLES.
`timescale 1ns/1ps

module tb_switch_debouncer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sw_raw = 2'b00;
    logic [1:0] sw_clean, sw_rise, sw_fall;
    logic [1:0] raw1 = 2'b00;
    logic [1:0] clean1, rise1, fall1;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    switch_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .sw_raw(sw_raw),
        .sw_clean(sw_clean), .sw_rise(sw_rise), .sw_fall(sw_fall)
    );

    switch_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .sw_raw(raw1),
        .sw_clean(clean1), .sw_rise(rise1), .sw_fall(fall1)
    );

    typedef struct {
        string      tag;
        logic [1:0] raw;
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string tag, input logic [1:0] r, input logic [1:0] c,
                       input logic [1:0] ri, input logic [1:0] f);
        vec_t v;
        v.tag = tag; v.raw = r; v.clean = c; v.rise = ri; v.fall = f;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic bpat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [11:0] exp1 [5];
        logic [1:0] b;
        int rise_edge, rise_cnt, fall_cnt, clean1_seen;

        // Idle low with no activity.
        for (int j = 0; j < 20; j++) add("idle", 2'b00, 2'b00, 2'b00, 2'b00);
        // Bit 0 goes high and is held. It changes at edge k+5.
        for (int j = 0; j < 8; j++)
            add("rise_a", 2'b01, (j >= 5) ? 2'b01 : 2'b00, (j == 5) ? 2'b01 : 2'b00, 2'b00);
        // Bit 1 bounces. The FSM sees four straight ones at edges 7..10.
        for (int j = 0; j < 13; j++) begin
            b = {((j < 6) ? bpat[j] : 1'b1), 1'b1};
            add("bounce_b", b, (j >= 10) ? 2'b11 : 2'b01, (j == 10) ? 2'b10 : 2'b00, 2'b00);
        end
        // Both bits release together and fall on the same edge.
        for (int j = 0; j < 8; j++)
            add("release", 2'b00, (j >= 5) ? 2'b00 : 2'b11, 2'b00, (j == 5) ? 2'b11 : 2'b00);
        // Toggling faster than the debounce window never changes the output.
        for (int j = 0; j < 12; j++) begin
            b = {((j % 4) < 2) ? 1'b1 : 1'b0, ((j % 2) == 0) ? 1'b1 : 1'b0};
            add("toggle", b, 2'b00, 2'b00, 2'b00);
        end
        for (int j = 0; j < 4; j++) add("settle", 2'b00, 2'b00, 2'b00, 2'b00);
        // Three ones and then a zero on the final check sample: rejected.
        for (int j = 0; j < 10; j++)
            add("last_bounce", (j < 3) ? 2'b01 : 2'b00, 2'b00, 2'b00, 2'b00);

        // Reset state.
        repeat (3) @(posedge clk);
        #1 check("reset_state", {sw_clean, sw_rise, sw_fall, clean1, rise1, fall1}, 12'h000);
        @(negedge clk) rst = 1'b0;

        // Table-driven vectors.
        foreach (vecs[i]) begin
            @(negedge clk) sw_raw = vecs[i].raw;
            @(posedge clk);
            #1;
            $display("vec %0d %s raw=%b clean=%b rise=%b fall=%b", i, vecs[i].tag,
                     vecs[i].raw, sw_clean, sw_rise, sw_fall);
            check(vecs[i].tag, {sw_clean, sw_rise, sw_fall, clean1, rise1, fall1},
                  {vecs[i].clean, vecs[i].rise, vecs[i].fall, 6'b0});
        end

        // Reset mid-check. First make bit 1 clean-high so the async clear is visible.
        @(negedge clk) sw_raw = 2'b10;
        repeat (7) @(posedge clk);
        #1 check("pre_reset_b_high", {10'b0, sw_clean}, {10'b0, 2'b10});
        @(negedge clk) sw_raw = 2'b11;
        repeat (3) @(posedge clk);   // bit 0 is now in its check phase
        @(negedge clk) rst = 1'b1;
        #1 check("async_clear", {6'b0, sw_clean, sw_rise, sw_fall}, 12'h000);
        repeat (2) @(posedge clk);
        #1 check("held_in_reset", {sw_clean, sw_rise, sw_fall, clean1, rise1, fall1}, 12'h000);
        @(negedge clk) begin rst = 1'b0; sw_raw = 2'b01; end
        // The first edge after release is k. Expect the change at edge k+5,
        // which is the sixth edge after release.
        rise_edge = 0; rise_cnt = 0; fall_cnt = 0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (sw_rise[0]) rise_cnt++;
            if (sw_fall != 2'b00) fall_cnt++;
            if (sw_clean[0] && rise_edge == 0) rise_edge = e;
        end
        $display("post_reset rise_edge=%0d rises=%0d falls=%0d clean=%b",
                 rise_edge, rise_cnt, fall_cnt, sw_clean);
        check("post_reset_rise_edge", 12'(rise_edge), 12'd6);
        check("post_reset_rise_count", 12'(rise_cnt), 12'd1);
        check("post_reset_no_fall", 12'(fall_cnt), 12'd0);
        check("post_reset_clean", {10'b0, sw_clean}, {10'b0, 2'b01});

        // Single-sample build: a one-cycle raw pulse on bit 0.
        exp1[0] = 12'h000;                       // edge k
        exp1[1] = 12'h000;                       // edge k+1
        exp1[2] = {6'b0, 2'b01, 2'b01, 2'b00};   // edge k+2 rises
        exp1[3] = {6'b0, 2'b00, 2'b00, 2'b01};   // edge k+3 falls
        exp1[4] = 12'h000;                       // edge k+4 quiet
        clean1_seen = 0;
        @(negedge clk) raw1 = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            $display("dc1 edge k+%0d clean=%b rise=%b fall=%b", i, clean1, rise1, fall1);
            check($sformatf("dc1_pulse_%0d", i), {6'b0, clean1, rise1, fall1}, exp1[i]);
            @(negedge clk) raw1 = 2'b00;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
